// File: rtl/bridge_pkg.sv
// Shared constants and helpers for the pr_bridge_multi peripheral bridge.
package bridge_pkg;

  localparam logic [31:0] DEF_BASE0    = 32'h0000_7F00;
  localparam logic [31:0] DEF_DEV_SPAN = 32'h0000_0010;
  localparam int          HWINT_W      = 6;
  localparam int          MAX_DEV      = 5;

  typedef enum logic [2:0] {
    ACC_IDLE,
    ACC_WRITE,
    ACC_READ,
    ACC_UNMAPPED_WR,
    ACC_UNMAPPED_RD,
    ACC_CONFLICT
  } acc_e;

  // Word-offset width inside one window; a 4-byte window still gets a 1-bit port.
  function automatic int off_width(input logic [31:0] span);
    return ($clog2(span) > 2) ? $clog2(span) - 2 : 1;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for the external interrupt; with BRIDGE_IRQ_LATCH_EN
// defined, a rising edge is held in a sticky pending flag until cleared.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic clr,
  output logic irq_out
);

  logic r_meta;
  logic r_sync;

  // NOTE: non-blocking assignments make both flops sample the pre-edge values,
  // giving a true two-stage chain instead of a single collapsed flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

`ifdef BRIDGE_IRQ_LATCH_EN
  logic r_sync_q;
  logic r_pending;
  logic w_rise;

  assign w_rise = r_sync & ~r_sync_q;

  // A rise in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_q  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_sync_q  <= r_sync;
      r_pending <= w_rise | (r_pending & ~clr);
    end
  end

  assign irq_out = r_pending | w_rise;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr;
  assign irq_out      = r_sync;
`endif

endmodule

// File: rtl/pr_bridge_multi.sv
// CPU peripheral-port bridge: window decode, strobes, registered read return,
// HWint collection. Optional sticky ext-int latch via BRIDGE_IRQ_LATCH_EN.
module pr_bridge_multi
  import bridge_pkg::*;
#(
  parameter int          N_DEV    = 2,
  parameter logic [31:0] BASE0    = DEF_BASE0,
  parameter logic [31:0] DEV_SPAN = DEF_DEV_SPAN,
  parameter int          HWINT_W  = bridge_pkg::HWINT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   pr_a,
  input  logic                          pr_we,
  input  logic                          pr_re,
  input  logic [31:0]                   pr_wd,
  input  logic [3:0]                    pr_be,
  output logic [31:0]                   pr_rd,
  output logic                          pr_rvalid,
  output logic                          pr_err,
  output logic [off_width(DEV_SPAN)-1:0] dev_off,
  output logic [31:0]                   dev_wd,
  output logic [3:0]                    dev_be,
  output logic [N_DEV-1:0]              dev_we,
  input  logic [32*N_DEV-1:0]           dev_rd,
  input  logic [N_DEV-1:0]              dev_irq,
  input  logic                          ext_int,
  output logic [HWINT_W-1:0]            HWint
);

  localparam int LOG_SPAN = $clog2(DEV_SPAN);

  if (N_DEV < 1 || N_DEV > MAX_DEV || HWINT_W <= N_DEV) begin : g_bad_cfg
    $error("pr_bridge_multi: N_DEV must be 1..MAX_DEV and below HWINT_W");
  end

  logic [31:0]        w_addr;
  logic               w_unused_a;
  logic [N_DEV-1:0]   w_sel;
  logic [31:0]        w_rd_mux;
  logic [31:0]        w_rd_data;
  logic               w_hit;
  logic               w_wr;
  logic               w_rd;
  logic               w_conflict;
  logic               w_clr_wr;
  logic               w_irq;
  acc_e               w_acc;
  logic [HWINT_W-1:0] w_hwint_d;

  logic [31:0]        r_rd;
  logic               r_rvalid;
  logic               r_err;
  logic [HWINT_W-1:0] r_hwint;

  assign w_addr     = {pr_a[31:2], 2'b00};
  assign w_unused_a = ^pr_a[1:0];

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sel    = '0;
    w_rd_mux = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if ((w_addr >= BASE0 + 32'(i) * DEV_SPAN) &&
          (w_addr - (BASE0 + 32'(i) * DEV_SPAN) < DEV_SPAN)) begin
        w_sel[i] = 1'b1;
      end
      if (w_sel[i]) begin
        w_rd_mux = w_rd_mux | dev_rd[32*i +: 32];
      end
    end
  end

  assign w_wr       = pr_we & ~pr_re;
  assign w_rd       = pr_re & ~pr_we;
  assign w_conflict = pr_we & pr_re;

`ifdef BRIDGE_IRQ_LATCH_EN
  localparam logic [31:0] CLR_ADDR = BASE0 + 32'(N_DEV) * DEV_SPAN;
  logic w_clr_hit;

  // The clear register sits one word past the last device window and counts as mapped.
  assign w_clr_hit = (w_addr == CLR_ADDR);
  assign w_hit     = (|w_sel) | w_clr_hit;
  assign w_clr_wr  = w_wr & w_clr_hit & pr_wd[0] & pr_be[0];
  assign w_rd_data = w_clr_hit ? {31'b0, w_irq} : w_rd_mux;
`else
  assign w_hit     = |w_sel;
  assign w_clr_wr  = 1'b0;
  assign w_rd_data = w_rd_mux;
`endif

  assign dev_we = w_sel & {N_DEV{w_wr}};
  assign dev_wd = pr_wd;
  assign dev_be = pr_be;

  if (LOG_SPAN > 2) begin : g_off
    assign dev_off = w_addr[LOG_SPAN-1:2];
  end else begin : g_off_none
    assign dev_off = '0;
  end

  always_comb begin
    w_acc = ACC_IDLE;
    if (w_conflict) begin
      w_acc = ACC_CONFLICT;
    end else if (w_wr) begin
      w_acc = w_hit ? ACC_WRITE : ACC_UNMAPPED_WR;
    end else if (w_rd) begin
      w_acc = w_hit ? ACC_READ : ACC_UNMAPPED_RD;
    end
  end

  irq_sync u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (ext_int),
    .clr      (w_clr_wr),
    .irq_out  (w_irq)
  );

  always_comb begin
    w_hwint_d              = '0;
    w_hwint_d[N_DEV-1:0]   = dev_irq;
    w_hwint_d[N_DEV]       = w_irq;
  end

  // Unmapped reads still return zero with rvalid so the CPU never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd     <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_hwint  <= '0;
    end else begin
      r_rvalid <= (w_acc == ACC_READ) || (w_acc == ACC_UNMAPPED_RD);
      r_err    <= (w_acc == ACC_UNMAPPED_WR) || (w_acc == ACC_UNMAPPED_RD) ||
                  (w_acc == ACC_CONFLICT);
      if (w_acc == ACC_READ) begin
        r_rd <= w_rd_data;
      end else if (w_acc == ACC_UNMAPPED_RD) begin
        r_rd <= '0;
      end
      r_hwint <= w_hwint_d;
    end
  end

  assign pr_rd     = r_rd;
  assign pr_rvalid = r_rvalid;
  assign pr_err    = r_err;
  assign HWint     = r_hwint;

endmodule

// File: tb/tb_pr_bridge_multi.sv
// Scoreboard bench for pr_bridge_multi (N_DEV=2, default windows, latch macro off).
module tb_pr_bridge_multi;

  localparam int          N_DEV = 2;
  localparam logic [31:0] BASE0 = 32'h0000_7F00;
  localparam logic [31:0] SPAN  = 32'h0000_0010;
  localparam int          HW_W  = 6;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [31:0]          pr_a;
  logic                 pr_we;
  logic                 pr_re;
  logic [31:0]          pr_wd;
  logic [3:0]           pr_be;
  logic [31:0]          pr_rd;
  logic                 pr_rvalid;
  logic                 pr_err;
  logic [1:0]           dev_off;
  logic [31:0]          dev_wd;
  logic [3:0]           dev_be;
  logic [N_DEV-1:0]     dev_we;
  logic [32*N_DEV-1:0]  dev_rd;
  logic [N_DEV-1:0]     dev_irq;
  logic                 ext_int;
  logic [HW_W-1:0]      HWint;

  pr_bridge_multi #(
    .N_DEV    (N_DEV),
    .BASE0    (BASE0),
    .DEV_SPAN (SPAN),
    .HWINT_W  (HW_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pr_a      (pr_a),
    .pr_we     (pr_we),
    .pr_re     (pr_re),
    .pr_wd     (pr_wd),
    .pr_be     (pr_be),
    .pr_rd     (pr_rd),
    .pr_rvalid (pr_rvalid),
    .pr_err    (pr_err),
    .dev_off   (dev_off),
    .dev_wd    (dev_wd),
    .dev_be    (dev_be),
    .dev_we    (dev_we),
    .dev_rd    (dev_rd),
    .dev_irq   (dev_irq),
    .ext_int   (ext_int),
    .HWint     (HWint)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  typedef struct {
    int          due;
    bit          rvalid;
    bit          err;
    logic [31:0] rd;
  } exp_t;

  exp_t             sb[$];
  logic [31:0]      rd_shown = '0;
  bit               run = 1'b0;
  bit [N_DEV-1:0]   irq_s [0:4095];
  bit               ext_s [0:4095];

  // Reference decode: which window (if any) a byte address falls in.
  function automatic int dev_index(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w >= BASE0 && (w - BASE0) < 32'(N_DEV) * SPAN) return int'((w - BASE0) / SPAN);
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0, 1, 2: return BASE0 + $urandom_range(0, N_DEV * SPAN - 1);
      3:       return BASE0 - 32'($urandom_range(1, 4));
      4:       return BASE0 + 32'(N_DEV) * SPAN + 32'($urandom_range(0, 3));
      5:       return BASE0 + 32'(N_DEV) * SPAN - 32'd4 + 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // Drive one request for the next clock edge; caller sets dev_rd/dev_irq/ext_int first.
  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    int               idx;
    exp_t             e;
    logic [N_DEV-1:0] exp_we;
    logic [31:0]      w;
    pr_we = we; pr_re = re; pr_a = a; pr_wd = wd; pr_be = be;
    idx = dev_index(a);
    w   = {a[31:2], 2'b00};
    irq_s[cyc+1] = reset ? '0 : dev_irq;
    ext_s[cyc+1] = reset ? 1'b0 : ext_int;
    if (!reset && (we || re)) begin
      e.due = cyc + 1; e.rd = '0; e.rvalid = 1'b0; e.err = 1'b0;
      if (we && re) e.err = 1'b1;
      else if (idx < 0) begin e.err = 1'b1; e.rvalid = re; end
      else if (re) begin e.rvalid = 1'b1; e.rd = dev_rd[32*idx +: 32]; end
      if (e.rvalid || e.err) sb.push_back(e);
    end
    exp_we = (we && !re && idx >= 0) ? N_DEV'(1 << idx) : '0;
    #2;
    check("dev_we", 32'(dev_we), 32'(exp_we));
    if (idx >= 0) check("dev_off", 32'(dev_off), ((w - BASE0) % SPAN) >> 2);
    check("dev_wd", dev_wd, wd);
    check("dev_be", 32'(dev_be), 32'(be));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Monitor: HWint against the latency model, responses against the scoreboard.
  always @(negedge clk) begin
    logic [HW_W-1:0] exp_hw;
    exp_t            e;
    if (run && !reset) begin
      exp_hw = '0;
      exp_hw[N_DEV-1:0] = irq_s[cyc];
      exp_hw[N_DEV]     = (cyc >= 2) ? ext_s[cyc-2] : 1'b0;
      check("hwint", 32'(HWint), 32'(exp_hw));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rvalid", 32'(pr_rvalid), 32'(e.rvalid));
        check("err", 32'(pr_err), 32'(e.err));
        if (e.rvalid) rd_shown = e.rd;
        check("rd", pr_rd, rd_shown);
      end else begin
        check("idle_rvalid", 32'(pr_rvalid), 32'd0);
        check("idle_err", 32'(pr_err), 32'd0);
        check("rd_hold", pr_rd, rd_shown);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    pr_a = '0; pr_we = 1'b0; pr_re = 1'b0; pr_wd = '0; pr_be = '0;
    dev_rd = '0; dev_irq = '0; ext_int = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_rd", pr_rd, 32'd0);
    check("reset_rvalid", 32'(pr_rvalid), 32'd0);
    check("reset_err", 32'(pr_err), 32'd0);
    check("reset_hwint", 32'(HWint), 32'd0);
    @(posedge clk); #1;
    idle(); idle();
    reset = 1'b0;
    run   = 1'b1;

    // Directed cases from the plan.
    step(1'b1, 1'b0, 32'h7F04, 32'hDEAD_BEEF, 4'hF);
    dev_rd = {32'h1234_5678, 32'h0BAD_F00D};
    step(1'b0, 1'b1, 32'h7F14, 32'h0, 4'hF);
    step(1'b0, 1'b1, 32'h7F80, 32'h0, 4'hF);
    step(1'b1, 1'b1, 32'h7F00, 32'h5555_AAAA, 4'hF);
    step(1'b1, 1'b0, 32'h7F20, 32'h1, 4'h1);
    idle();
    dev_irq = 2'b10; ext_int = 1'b1;
    idle();
    ext_int = 1'b0;
    repeat (5) idle();
    dev_irq = '0;

    // Randomized traffic.
    repeat (400) begin
      dev_rd = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) dev_irq = N_DEV'($urandom);
      ext_int = ($urandom_range(0, 3) == 0);
      op = int'($urandom_range(0, 9));
      if (op <= 2)      step(1'b0, 1'b0, rand_addr(), $urandom, 4'($urandom));
      else if (op <= 5) step(1'b1, 1'b0, rand_addr(), $urandom, 4'($urandom));
      else if (op <= 8) step(1'b0, 1'b1, rand_addr(), $urandom, 4'($urandom));
      else              step(1'b1, 1'b1, rand_addr(), $urandom, 4'($urandom));
    end

    // Back-to-back mapped reads.
    repeat (8) begin
      dev_rd = {$urandom, $urandom};
      step(1'b0, 1'b1, BASE0 + $urandom_range(0, N_DEV * SPAN - 1), 32'h0, 4'hF);
    end

    // Reset between a read request and its response edge.
    ext_int = 1'b0; dev_irq = 2'b11;
    dev_rd = {$urandom, $urandom | 32'h1};
    step(1'b0, 1'b1, BASE0, 32'h0, 4'hF);
    idle(); idle();
    pr_re = 1'b1; pr_a = BASE0 + SPAN; dev_rd = {$urandom | 32'h1, $urandom};
    #2;
    reset = 1'b1;
    rd_shown = '0;
    #1;
    check("midrst_rd", pr_rd, 32'd0);
    check("midrst_rvalid", 32'(pr_rvalid), 32'd0);
    check("midrst_err", 32'(pr_err), 32'd0);
    check("midrst_hwint", 32'(HWint), 32'd0);
    pr_re = 1'b0;
    @(posedge clk); #1;
    idle(); idle();
    reset = 1'b0;
    repeat (4) idle();

    repeat (3) idle();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
